// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
package imem_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } imem_state_e;

    localparam logic [31:0] IMEM_DEFAULT_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Word RAM with one synchronous write port and one registered read port.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself is never reset so program contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_memory_sync.sv
// Instruction memory with a streaming program loader and 1-cycle fetch port.
//   state | meaning
//   RUN   | fetches accepted (ready=1), loader stream ignored
//   LOAD  | fetches stalled, prog_valid words written at the pointer
module instruction_memory_sync
    import imem_pkg::*;
#(
    parameter int                 ADDR_W       = 32,
    parameter int                 DATA_W       = 32,
    parameter int                 DEPTH        = 64,
    parameter logic [DATA_W-1:0]  DEFAULT_WORD = DATA_W'(IMEM_DEFAULT_WORD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic [ADDR_W-1:0]        a,
    output logic                     ready,
    output logic [DATA_W-1:0]        rd,
    output logic                     rd_valid,
    output logic                     fault,
    input  logic                     prog_start,
    input  logic                     prog_valid,
    input  logic [DATA_W-1:0]        prog_data,
    input  logic                     prog_last,
    output logic [$clog2(DEPTH):0]   prog_count,
    output logic                     prog_ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    imem_state_e        state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               ovf_d;
    logic               we;
    logic               accept;
    logic               misalign, oob;
    logic               valid_q, fault_q;
    logic [DATA_W-1:0]  ram_q;

    assign ready    = (state_q == RUN);
    assign accept   = req && ready;
    assign misalign = |a[1:0];
    // Full upper-bit compare: addresses past DEPTH must fault, never alias.
    assign oob      = a[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = prog_ovf;
        we      = 1'b0;
        case (state_q)
            RUN: begin
                if (prog_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (prog_start) begin
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else if (prog_valid) begin
                    if (ptr_q != PTR_W'(DEPTH)) begin
                        we    = 1'b1;
                        ptr_d = ptr_q + PTR_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (prog_last) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ptr_q    <= '0;
            prog_ovf <= 1'b0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            prog_ovf <= ovf_d;
            valid_q  <= accept;
            if (accept) begin
                fault_q <= misalign || oob;
            end
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (ptr_q[AW-1:0]),
        .wdata (prog_data),
        .re    (accept),
        .raddr (a[AW+1:2]),
        .rdata (ram_q)
    );

    // fault_q and ram_q both hold between fetches, so rd holds too.
    assign rd         = fault_q ? DEFAULT_WORD : ram_q;
    assign rd_valid   = valid_q;
    assign fault      = fault_q;
    assign prog_count = ptr_q;

endmodule
